// File: rtl/parking_slot_allocator_pkg.sv
// Shared types and constants for the parking slot allocator and the display logic.
package parking_pkg;

    localparam int unsigned NUM_SLOTS_DEFAULT = 4;
    localparam int unsigned STATS_W           = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    // Slot index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parking_slot_allocator_if.sv
// Gate/controller-side bundle of the parking slot allocator.
// PARK_STATS_EN adds the entry statistics counters to the bundle.
interface parking_slot_allocator_if
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEFAULT
);

    localparam int unsigned IDX_W = idx_width(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

    logic                 enter_req;
    logic                 enter_ack;
    logic                 enter_nack;
    logic [IDX_W-1:0]     grant_slot;
    logic                 exit_req;
    logic [IDX_W-1:0]     exit_slot;
    logic [NUM_SLOTS-1:0] occupancy;
    logic [CNT_W-1:0]     free_count;
    logic                 full;
    logic                 empty;
    logic                 err;
`ifdef PARK_STATS_EN
    logic [STATS_W-1:0]   total_entries;
    logic [STATS_W-1:0]   refused_entries;

    modport slave (
        input  enter_req, exit_req, exit_slot,
        output enter_ack, enter_nack, grant_slot, occupancy, free_count,
               full, empty, err, total_entries, refused_entries
    );

    modport master (
        output enter_req, exit_req, exit_slot,
        input  enter_ack, enter_nack, grant_slot, occupancy, free_count,
               full, empty, err, total_entries, refused_entries
    );
`else
    modport slave (
        input  enter_req, exit_req, exit_slot,
        output enter_ack, enter_nack, grant_slot, occupancy, free_count,
               full, empty, err
    );

    modport master (
        output enter_req, exit_req, exit_slot,
        input  enter_ack, enter_nack, grant_slot, occupancy, free_count,
               full, empty, err
    );
`endif

endinterface

// File: rtl/parking_slot_allocator_lowest_free_encoder.sv
// Combinational priority encoder: lowest set bit of the free-slot map.
module lowest_free_encoder
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEFAULT,
    parameter int unsigned IDX_W     = idx_width(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS-1:0] i_free_map,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any_free
);

    // Scan downwards so the last (lowest) free bit wins.
    always_comb begin
        o_idx      = '0;
        o_any_free = |i_free_map;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (i_free_map[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/parking_slot_allocator.sv
// N-slot parking allocator: grants the lowest free slot once per request, releases on exit.
// Optional macro PARK_STATS_EN adds saturating total/refused entry counters.
module parking_slot_allocator
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    parking_slot_allocator_if.slave  bus
);

    localparam int unsigned IDX_W = idx_width(NUM_SLOTS);
    localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [CNT_W-1:0] ALL_FREE = CNT_W'(NUM_SLOTS);

    state_e               r_state;
    state_e               w_state_nxt;

    logic [NUM_SLOTS-1:0] r_occ;
    logic [CNT_W-1:0]     r_free_cnt;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_ack;
    logic                 r_nack;
    logic                 r_err;
    logic [IDX_W-1:0]     r_grant_slot;

    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_any_free;
    logic                 w_exit_in_range;
    logic                 w_exit_legal;
    logic [NUM_SLOTS-1:0] w_exit_mask;
    logic [NUM_SLOTS-1:0] w_grant_mask;
    logic                 w_do_grant;
    logic                 w_do_nack;
    logic                 w_err_nxt;
    logic [NUM_SLOTS-1:0] w_occ_nxt;
    logic [CNT_W-1:0]     w_free_cnt_nxt;

    lowest_free_encoder #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_lowest_free (
        .i_free_map (~r_occ),
        .o_idx      (w_free_idx),
        .o_any_free (w_any_free)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One pass through GRANT per request assertion; WAIT_REL swallows a held request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (bus.enter_req)  w_state_nxt = GRANT;
            GRANT:                        w_state_nxt = WAIT_REL;
            WAIT_REL: if (!bus.enter_req) w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    // Grant is decided on the pre-exit map, so a slot freed this cycle is not reused yet.
    always_comb begin
        w_do_grant      = 1'b0;
        w_do_nack       = 1'b0;
        w_exit_in_range = 32'(bus.exit_slot) < NUM_SLOTS;
        w_exit_legal    = bus.exit_req && w_exit_in_range && r_occ[bus.exit_slot];
        w_err_nxt       = bus.exit_req && !w_exit_legal;
        w_exit_mask     = w_exit_legal ? (NUM_SLOTS'(1) << bus.exit_slot) : '0;
        w_grant_mask    = '0;
        if (r_state == GRANT) begin
            w_do_grant   = w_any_free;
            w_do_nack    = !w_any_free;
            w_grant_mask = w_any_free ? (NUM_SLOTS'(1) << w_free_idx) : '0;
        end
        w_occ_nxt      = (r_occ | w_grant_mask) & ~w_exit_mask;
        w_free_cnt_nxt = r_free_cnt - CNT_W'(w_do_grant) + CNT_W'(w_exit_legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ        <= '0;
            r_free_cnt   <= ALL_FREE;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_ack        <= 1'b0;
            r_nack       <= 1'b0;
            r_err        <= 1'b0;
            r_grant_slot <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_free_cnt <= w_free_cnt_nxt;
            r_full     <= (w_free_cnt_nxt == '0);
            r_empty    <= (w_free_cnt_nxt == ALL_FREE);
            r_ack      <= w_do_grant;
            r_nack     <= w_do_nack;
            r_err      <= w_err_nxt;
            if (w_do_grant) begin
                r_grant_slot <= w_free_idx;
            end
        end
    end

    assign bus.enter_ack  = r_ack;
    assign bus.enter_nack = r_nack;
    assign bus.grant_slot = r_grant_slot;
    assign bus.occupancy  = r_occ;
    assign bus.free_count = r_free_cnt;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.err        = r_err;

`ifdef PARK_STATS_EN
    logic [STATS_W-1:0] r_total_entries;
    logic [STATS_W-1:0] r_refused_entries;

    // Saturating counters, updated on the same edge that raises ack/nack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total_entries   <= '0;
            r_refused_entries <= '0;
        end else begin
            if (w_do_grant && (r_total_entries != '1)) begin
                r_total_entries <= r_total_entries + STATS_W'(1);
            end
            if (w_do_nack && (r_refused_entries != '1)) begin
                r_refused_entries <= r_refused_entries + STATS_W'(1);
            end
        end
    end

    assign bus.total_entries   = r_total_entries;
    assign bus.refused_entries = r_refused_entries;
`endif

endmodule
